// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU memory-port arbiter: FSM states, owner codes
// and the word-alignment helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic       OWN_IF          = 1'b0;
    localparam logic       OWN_D           = 1'b1;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return (i_lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Wait counter for the ACCESS state: counts cycles without mem_ready and
// flags expiry on the last permitted cycle.
module arb_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int            CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage, with
// starvation protection, alignment rejection and a memory timeout.
//
// state      | meaning
// ARB_IDLE   | no transaction; arbitrate between if_req and d_req
// ARB_ACCESS | mem_en high, waiting for mem_ready or timeout
// ARB_RESP   | one-cycle ack/err pulse to the owner
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8,
    parameter int DSTARVE  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ack,
    output logic          o_if_err,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_ack,
    output logic          o_d_err,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_ready,
    output logic          o_busy,
    output logic          o_owner
);
    localparam int SW = (DSTARVE > 0) ? $clog2(DSTARVE + 1) : 1;

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_owner;
    logic          r_err;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic [SW-1:0] r_starve;

    logic          w_grant_d;
    logic          w_grant_if;
    logic [AW-1:0] w_sel_addr;
    logic          w_starve_full;
    logic          w_expired;
    logic          w_in_access;

    assign w_starve_full = (r_starve == SW'(DSTARVE));
    assign w_in_access   = (r_state == ARB_ACCESS);

    arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode from state so an async reset drops the strobes at once.
    always_comb begin
        w_next       = r_state;
        w_grant_d    = 1'b0;
        w_grant_if   = 1'b0;
        w_sel_addr   = i_if_addr;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_wdata;
        o_if_ack     = 1'b0;
        o_d_ack      = 1'b0;
        o_if_err     = 1'b0;
        o_d_err      = 1'b0;
        o_busy       = (r_state != ARB_IDLE);
        o_owner      = r_owner;
        o_if_rdata   = r_if_rdata;
        o_d_rdata    = r_d_rdata;
        case (r_state)
            ARB_IDLE: begin
                w_grant_d  = i_d_req && !(w_starve_full && i_if_req);
                w_grant_if = !w_grant_d && i_if_req;
                w_sel_addr = w_grant_d ? i_d_addr : i_if_addr;
                if (w_grant_d || w_grant_if) begin
                    w_next = is_misaligned(w_sel_addr[1:0]) ? ARB_RESP : ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                o_mem_en = 1'b1;
                o_mem_we = r_we;
                if (i_mem_ready || w_expired) begin
                    w_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                o_if_ack = (r_owner == OWN_IF);
                o_d_ack  = (r_owner == OWN_D);
                o_if_err = (r_owner == OWN_IF) && r_err;
                o_d_err  = (r_owner == OWN_D) && r_err;
                w_next   = ARB_IDLE;
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_owner    <= OWN_IF;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_starve   <= '0;
        end else begin
            if (w_grant_d || w_grant_if) begin
                r_addr  <= w_sel_addr;
                r_we    <= w_grant_d && i_d_we;
                r_wdata <= w_grant_d ? i_d_wdata : '0;
                r_owner <= w_grant_d ? OWN_D : OWN_IF;
                r_err   <= is_misaligned(w_sel_addr[1:0]);
                if (w_grant_d && i_if_req) begin
                    if (!w_starve_full) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end else begin
                    r_starve <= '0;
                end
            end
            if (w_in_access) begin
                if (i_mem_ready) begin
                    r_err <= 1'b0;
                    if (!r_we) begin
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= i_mem_rdata;
                        end else begin
                            r_if_rdata <= i_mem_rdata;
                        end
                    end
                end else if (w_expired) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/load/store, misalignment,
// timeout, starvation order and asynchronous reset during an access.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = '0;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [9:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy, owner;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(10), .DW(32), .MAX_WAIT(8), .DSTARVE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (if_ack),
        .o_if_err    (if_err),
        .o_if_rdata  (if_rdata),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_ack     (d_ack),
        .o_d_err     (d_err),
        .o_d_rdata   (d_rdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_busy      (busy),
        .o_owner     (owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises one request, waits for its ack, and reports what was seen on the
    // memory port along the way.
    task automatic run_req(input logic is_d, input logic we, input logic [9:0] addr,
                           input logic [31:0] wdata, output int lat, output int en_cyc,
                           output logic err, output logic s_we, output logic [9:0] s_addr,
                           output logic [31:0] s_wdata, output int wrong_ack);
        lat = 0; en_cyc = 0; err = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; wrong_ack = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 40; c++) begin
            step();
            if (mem_en) begin
                en_cyc++; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
            end
            if (is_d ? if_ack : d_ack) wrong_ack++;
            if (is_d ? d_ack : if_ack) begin
                lat = c;
                err = is_d ? d_err : if_err;
                break;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("ack_seen", 32'(lat != 0), 32'd1);
    endtask

    int          lat, en_cyc, wrong;
    logic        err, s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;
    logic        exp_own [6];
    int          n_grant;

    initial begin
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // fetch, zero wait
        mem_ready = 1'b1; mem_rdata = 32'h2001_0005;
        run_req(1'b0, 1'b0, 10'h004, 32'h0, lat, en_cyc, err, s_we, s_addr, s_wdata, wrong);
        chk("f_lat", 32'(lat), 32'd2);
        chk("f_en_cyc", 32'(en_cyc), 32'd1);
        chk("f_addr", 32'(s_addr), 32'h004);
        chk("f_we", 32'(s_we), 32'd0);
        chk("f_err", 32'(err), 32'd0);
        chk("f_rdata", if_rdata, 32'h2001_0005);
        chk("f_wrong_ack", 32'(wrong), 32'd0);
        step();
        chk("f_ack_1cyc", 32'({if_ack, d_ack}), 32'd0);
        chk("f_idle", 32'(busy), 32'd0);

        // store: memory drives a decoy word that must not reach d_rdata
        mem_rdata = 32'h1234_5678;
        run_req(1'b1, 1'b1, 10'h040, 32'hDEAD_BEEF, lat, en_cyc, err, s_we, s_addr, s_wdata, wrong);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_we", 32'(s_we), 32'd1);
        chk("st_addr", 32'(s_addr), 32'h040);
        chk("st_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("st_err", 32'(err), 32'd0);
        chk("st_d_rdata", d_rdata, 32'd0);
        chk("st_wrong_ack", 32'(wrong), 32'd0);
        step();

        // load
        mem_rdata = 32'hDEAD_BEEF;
        run_req(1'b1, 1'b0, 10'h040, 32'h0, lat, en_cyc, err, s_we, s_addr, s_wdata, wrong);
        chk("ld_lat", 32'(lat), 32'd2);
        chk("ld_we", 32'(s_we), 32'd0);
        chk("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("ld_if_rdata", if_rdata, 32'h2001_0005);
        step();

        // misaligned data access
        mem_rdata = 32'h5555_AAAA;
        run_req(1'b1, 1'b0, 10'h042, 32'h0, lat, en_cyc, err, s_we, s_addr, s_wdata, wrong);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_en_cyc", 32'(en_cyc), 32'd0);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_d_rdata", d_rdata, 32'hDEAD_BEEF);
        step();

        // timeout on fetch
        mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
        run_req(1'b0, 1'b0, 10'h008, 32'h0, lat, en_cyc, err, s_we, s_addr, s_wdata, wrong);
        chk("to_en_cyc", 32'(en_cyc), 32'd8);
        chk("to_lat", 32'(lat), 32'd9);
        chk("to_err", 32'(err), 32'd1);
        chk("to_if_rdata", if_rdata, 32'h2001_0005);
        chk("to_wrong_ack", 32'(wrong), 32'd0);
        step();

        // starvation: both requesters held high throughout
        mem_ready = 1'b1; mem_rdata = 32'h0000_1111;
        d_we = 1'b0; d_addr = 10'h080; if_addr = 10'h00C;
        d_req = 1'b1; if_req = 1'b1;
        n_grant = 0;
        for (int c = 0; c < 60 && n_grant < 6; c++) begin
            step();
            if (mem_en) begin
                chk($sformatf("starve_g%0d", n_grant), 32'(owner), 32'(exp_own[n_grant]));
                n_grant++;
            end
            if (if_ack && d_ack) chk("starve_dual_ack", 32'd1, 32'd0);
        end
        chk("starve_grants", 32'(n_grant), 32'd6);
        d_req = 1'b0; if_req = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("starve_idle", 32'(busy), 32'd0);

        // async reset during a stalled data access
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        step();
        chk("ra_mem_en", 32'(mem_en), 32'd1);
        chk("ra_owner", 32'(owner), 32'd1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("ra_rst_mem_en", 32'(mem_en), 32'd0);
        chk("ra_rst_busy", 32'(busy), 32'd0);
        chk("ra_rst_owner", 32'(owner), 32'd0);
        chk("ra_rst_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        #2;
        rst_n = 1'b1;
        wrong = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (if_ack || d_ack || mem_en) wrong++;
        end
        chk("ra_no_ack", 32'(wrong), 32'd0);

        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        run_req(1'b0, 1'b0, 10'h010, 32'h0, lat, en_cyc, err, s_we, s_addr, s_wdata, wrong);
        chk("rec_lat", 32'(lat), 32'd2);
        chk("rec_err", 32'(err), 32'd0);
        chk("rec_rdata", if_rdata, 32'hCAFE_0001);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
